uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..256).
REQ-002 SHALL have parameter LW, default $clog2(DEPTH)+1, level width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 uart_rx_data  input  8  received byte from uart receiver.
REQ-007 uart_rx_new_it  input  1  one-cycle pulse; byte valid.
REQ-008 uart_rx_par_it  input  1  parity error for current byte.
REQ-009 uart_rx_frm_it  input  1  framing error for current byte.
REQ-010 cfg_drop_err  input  1  discard bytes flagged par/frm.
REQ-011 cfg_thresh  input  LW  level threshold; 0 disables fifo_thr_it.
REQ-012 fifo_clr  input  1  synchronous flush.
REQ-013 fifo_pop  input  1  consume head entry.
REQ-014 fifo_rdata  output  8  head data (show-ahead).
REQ-015 fifo_rpar_err / fifo_rfrm_err  output  1 each  head error flags.
REQ-016 fifo_empty / fifo_full  output  1 each  status.
REQ-017 fifo_level  output  LW  entries stored, 0..DEPTH.
REQ-018 fifo_ovf_it  output  1  one-cycle pulse on lost byte.
REQ-019 fifo_thr_it  output  1  level interrupt.
REQ-020 fifo_drop_cnt  output  8  saturating count of error bytes discarded.

Function
REQ-021 uart_rx_data, par_it, frm_it SHALL be sampled in the cycle uart_rx_new_it=1.
REQ-022 Push request = new_it and not (cfg_drop_err and (par_it or frm_it)).
REQ-023 Discarded error byte SHALL increment fifo_drop_cnt, saturating at 255.
REQ-024 Push at edge N SHALL make entry visible (fifo_empty=0, fifo_rdata valid) after edge N; 1-cycle latency.
REQ-025 fifo_rdata/err flags SHALL present the oldest entry whenever fifo_empty=0; pop advances head at the edge.
REQ-026 Pop with fifo_empty=1 SHALL be ignored; no state change.
REQ-027 Push with fifo_full=1 and no pop SHALL discard the byte and pulse fifo_ovf_it for one cycle after the edge.
REQ-028 Simultaneous push and pop when full SHALL both succeed; level unchanged; no overflow.
REQ-029 Simultaneous push and pop when empty SHALL push only; pop ignored; level becomes 1.
REQ-030 fifo_level SHALL be +1 push-only, -1 pop-only, unchanged otherwise.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH; full = level==DEPTH, empty = level==0.
REQ-032 fifo_thr_it SHALL be registered, high while level >= cfg_thresh and cfg_thresh != 0.
REQ-033 fifo_clr SHALL zero pointers and level, overriding same-cycle push/pop; fifo_drop_cnt also cleared; ovf pulse suppressed.

Reset
REQ-034 rst SHALL force: pointers 0, fifo_level 0, fifo_empty 1, fifo_full 0, fifo_ovf_it 0, fifo_thr_it 0, fifo_drop_cnt 0, fifo_rdata 0, err flags 0.
REQ-035 rst asserted mid-operation SHALL discard all contents in one edge; storage contents need not be cleared.
REQ-036 new_it coincident with rst SHALL be ignored.

Structure
REQ-037 Shared package uart_pkg SHALL hold entry struct {data[7:0], par, frm} and default depth constant.
REQ-038 Storage SHALL be sub-module uart_fifo_mem (one write port, one async read port, no reset).

Verification
REQ-039 Push 0xCA, 0x53 -> fifo_rdata 0xCA, level 2; pop -> 0x53, level 1; pop -> empty=1.
REQ-040 Push 9 bytes 0x80..0x88 at DEPTH=8 -> full=1, one ovf_it pulse on 9th, head 0x80, 0x88 absent.
REQ-041 Full FIFO, push 0x41 with pop same cycle -> level stays 8, tail 0x41, no ovf_it.
REQ-042 cfg_drop_err=1, push 0xF8 with par_it=1 -> not stored, drop_cnt=1; cfg_drop_err=0 -> stored with fifo_rpar_err=1.
REQ-043 cfg_thresh=3, push 3 bytes -> thr_it rises after 3rd; pop -> falls next cycle.
REQ-044 Level 5, fifo_clr with push same cycle -> level 0, empty=1; then rst mid-push -> all reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO.
// One stored entry is the received byte plus its two error flags.
package uart_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       frm;
  } uart_entry_t;

  localparam int UART_FIFO_DEPTH = 8;
  localparam int UART_ENTRY_W    = $bits(uart_entry_t);

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// There is no reset; validity of the contents is tracked by the controller.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [UART_ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]           i_raddr,
  output logic [UART_ENTRY_W-1:0] o_rdata
);

  logic [UART_ENTRY_W-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: optional error-byte dropping,
// show-ahead head, overflow pulse, level threshold interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    uart_rx_data,
  input  logic          uart_rx_new_it,
  input  logic          uart_rx_par_it,
  input  logic          uart_rx_frm_it,
  input  logic          cfg_drop_err,
  input  logic [LW-1:0] cfg_thresh,
  input  logic          fifo_clr,
  input  logic          fifo_pop,
  output logic [7:0]    fifo_rdata,
  output logic          fifo_rpar_err,
  output logic          fifo_rfrm_err,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [LW-1:0] fifo_level,
  output logic          fifo_ovf_it,
  output logic          fifo_thr_it,
  output logic [7:0]    fifo_drop_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_thr;
  logic [7:0]    r_drop_cnt;

  logic          w_push_req;
  logic          w_drop;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_we;
  logic [LW-1:0] w_level_nxt;
  logic          w_thr_nxt;
  uart_entry_t   w_wentry;
  uart_entry_t   w_head;
  logic [UART_ENTRY_W-1:0] w_head_raw;

  // Push/pop qualification and next level
  always_comb begin
    w_push_req = uart_rx_new_it & ~(cfg_drop_err & (uart_rx_par_it | uart_rx_frm_it));
    w_drop     = uart_rx_new_it & cfg_drop_err & (uart_rx_par_it | uart_rx_frm_it);
    w_empty    = (r_level == {LW{1'b0}});
    w_full     = (r_level == FULL_LVL);
    w_pop      = fifo_pop & ~w_empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push
    w_push     = w_push_req & (~w_full | w_pop);
    w_we       = w_push & ~rst & ~fifo_clr;
    if (fifo_clr) begin
      w_level_nxt = {LW{1'b0}};
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end else begin
      w_level_nxt = r_level;
    end
    w_thr_nxt = (cfg_thresh != {LW{1'b0}}) && (w_level_nxt >= cfg_thresh);
  end

  // Pointers, level, interrupts and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_ovf      <= 1'b0;
      r_thr      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (fifo_clr) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_ovf      <= 1'b0;
      r_thr      <= w_thr_nxt;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_ovf   <= w_push_req & w_full & ~w_pop;
      r_thr   <= w_thr_nxt;
      if (w_drop && r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_wentry.data = uart_rx_data;
    w_wentry.par  = uart_rx_par_it;
    w_wentry.frm  = uart_rx_frm_it;
    w_head        = uart_entry_t'(w_head_raw);
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wentry),
    .i_raddr (r_rptr),
    .o_rdata (w_head_raw)
  );

  // Head is masked while empty so stale storage never reaches the outputs
  assign fifo_rdata    = w_empty ? 8'h00 : w_head.data;
  assign fifo_rpar_err = w_empty ? 1'b0  : w_head.par;
  assign fifo_rfrm_err = w_empty ? 1'b0  : w_head.frm;
  assign fifo_empty    = w_empty;
  assign fifo_full     = w_full;
  assign fifo_level    = r_level;
  assign fifo_ovf_it   = r_ovf;
  assign fifo_thr_it   = r_thr;
  assign fifo_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at DEPTH=8.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    uart_rx_data = 8'h00;
  logic          uart_rx_new_it = 1'b0;
  logic          uart_rx_par_it = 1'b0;
  logic          uart_rx_frm_it = 1'b0;
  logic          cfg_drop_err = 1'b0;
  logic [LW-1:0] cfg_thresh = 4'd0;
  logic          fifo_clr = 1'b0;
  logic          fifo_pop = 1'b0;
  logic [7:0]    fifo_rdata;
  logic          fifo_rpar_err, fifo_rfrm_err, fifo_empty, fifo_full;
  logic [LW-1:0] fifo_level;
  logic          fifo_ovf_it, fifo_thr_it;
  logic [7:0]    fifo_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .uart_rx_data(uart_rx_data), .uart_rx_new_it(uart_rx_new_it),
    .uart_rx_par_it(uart_rx_par_it), .uart_rx_frm_it(uart_rx_frm_it),
    .cfg_drop_err(cfg_drop_err), .cfg_thresh(cfg_thresh),
    .fifo_clr(fifo_clr), .fifo_pop(fifo_pop),
    .fifo_rdata(fifo_rdata), .fifo_rpar_err(fifo_rpar_err), .fifo_rfrm_err(fifo_rfrm_err),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .fifo_ovf_it(fifo_ovf_it), .fifo_thr_it(fifo_thr_it), .fifo_drop_cnt(fifo_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle past the rising edge
  task automatic cyc(input logic nw, input logic [7:0] d, input logic par, input logic frm,
                     input logic pop, input logic clr, input logic rs);
    @(negedge clk);
    uart_rx_new_it = nw;
    uart_rx_data   = d;
    uart_rx_par_it = par;
    uart_rx_frm_it = frm;
    fifo_pop       = pop;
    fifo_clr       = clr;
    rst            = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_level"}, int'(fifo_level), 0);
    check({tag, "_empty"}, int'(fifo_empty), 1);
    check({tag, "_full"},  int'(fifo_full), 0);
    check({tag, "_ovf"},   int'(fifo_ovf_it), 0);
    check({tag, "_thr"},   int'(fifo_thr_it), 0);
    check({tag, "_drop"},  int'(fifo_drop_cnt), 0);
    check({tag, "_rdata"}, int'(fifo_rdata), 0);
    check({tag, "_rpar"},  int'(fifo_rpar_err), 0);
    check({tag, "_rfrm"},  int'(fifo_rfrm_err), 0);
  endtask

  initial begin
    logic [7:0] exp_q [$];

    // Reset, with a coincident byte that must be ignored
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset("rst");
    idle();
    check("rst_newit_ignored", int'(fifo_level), 0);

    // Basic order and one-cycle visibility
    push(8'hCA);
    check("p1_empty", int'(fifo_empty), 0);
    check("p1_rdata", int'(fifo_rdata), 8'hCA);
    push(8'h53);
    check("p2_rdata", int'(fifo_rdata), 8'hCA);
    check("p2_level", int'(fifo_level), 2);
    pop1();
    check("pop1_rdata", int'(fifo_rdata), 8'h53);
    check("pop1_level", int'(fifo_level), 1);
    pop1();
    check("pop2_empty", int'(fifo_empty), 1);
    pop1();
    check("pop_empty_ignored", int'(fifo_level), 0);

    // Fill past full: the 9th byte is lost with a single ovf pulse
    for (int i = 0; i < 9; i++) begin
      push(8'h80 + 8'(i));
      if (i == 7) begin
        check("fill_full", int'(fifo_full), 1);
        check("fill_no_ovf", int'(fifo_ovf_it), 0);
      end
    end
    check("ovf_pulse", int'(fifo_ovf_it), 1);
    check("ovf_level", int'(fifo_level), 8);
    check("ovf_head", int'(fifo_rdata), 8'h80);
    idle();
    check("ovf_one_cycle", int'(fifo_ovf_it), 0);

    // Push and pop together when full
    cyc(1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pp_full_level", int'(fifo_level), 8);
    check("pp_full_no_ovf", int'(fifo_ovf_it), 0);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back(8'h41);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), int'(fifo_rdata), int'(exp_q[i]));
      pop1();
    end
    check("drain_empty", int'(fifo_empty), 1);

    // Push and pop together when empty: push only
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pp_empty_level", int'(fifo_level), 1);
    check("pp_empty_rdata", int'(fifo_rdata), 8'h5A);
    pop1();

    // Error handling
    cfg_drop_err = 1'b1;
    cyc(1'b1, 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drop_level", int'(fifo_level), 0);
    check("drop_cnt", int'(fifo_drop_cnt), 1);
    cfg_drop_err = 1'b0;
    cyc(1'b1, 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("keep_level", int'(fifo_level), 1);
    check("keep_rdata", int'(fifo_rdata), 8'hF8);
    check("keep_rpar", int'(fifo_rpar_err), 1);
    check("keep_rfrm", int'(fifo_rfrm_err), 0);
    check("keep_drop_cnt", int'(fifo_drop_cnt), 1);
    pop1();
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("frm_rfrm", int'(fifo_rfrm_err), 1);
    check("frm_rpar", int'(fifo_rpar_err), 0);
    pop1();

    // Threshold interrupt
    cfg_thresh = 4'd3;
    push(8'h01);
    push(8'h02);
    check("thr_below", int'(fifo_thr_it), 0);
    push(8'h03);
    check("thr_rise", int'(fifo_thr_it), 1);
    pop1();
    idle();
    check("thr_fall", int'(fifo_thr_it), 0);
    cfg_thresh = 4'd0;

    // Flush overriding a same-cycle push, from level 5
    push(8'h04);
    push(8'h05);
    push(8'h06);
    check("lvl5", int'(fifo_level), 5);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_level", int'(fifo_level), 0);
    check("clr_empty", int'(fifo_empty), 1);
    check("clr_drop", int'(fifo_drop_cnt), 0);

    // Drop counter saturation
    cfg_drop_err = 1'b1;
    for (int i = 0; i < 258; i++) cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drop_sat", int'(fifo_drop_cnt), 255);
    cfg_drop_err = 1'b0;

    // Reset mid-operation with a push in flight
    cfg_thresh = 4'd1;
    push(8'hA1);
    push(8'hA2);
    check("pre_rst_thr", int'(fifo_thr_it), 1);
    cyc(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset("mid_rst");
    cfg_thresh = 4'd0;
    idle();
    push(8'hB0);
    check("post_rst_rdata", int'(fifo_rdata), 8'hB0);
    check("post_rst_level", int'(fifo_level), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
